// File: rtl/disp_demux.sv
// disp_demux: rebuilds eight seven-segment digit bytes from a multiplexed anode/segment bus
module disp_demux #(
    parameter int STABLE_CYCLES = 16,
    parameter int CW = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] an_in,
    input  logic [7:0] sseg_in,
    input  logic       clear,
    output logic [7:0] out7,
    output logic [7:0] out6,
    output logic [7:0] out5,
    output logic [7:0] out4,
    output logic [7:0] out3,
    output logic [7:0] out2,
    output logic [7:0] out1,
    output logic [7:0] out0,
    output logic [7:0] valid,
    output logic       frame_tick,
    output logic       err_multi
);
    logic [15:0] s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] valid_q, valid_d, seen_q, seen_d, lit, dec;
    logic err_q, err_d, tick_q, tick_d, eq, cap, one_hot, frame;
    logic [7:0] out_q [8];

    // Stability detection, anode decode and next status; clear overrides this cycle's status updates
    always_comb begin
        eq = s1_q == s2_q;
        cap = eq && (cnt_q == CW'(STABLE_CYCLES - 1));
        cnt_d = !eq ? '0 : (cnt_q != CW'(STABLE_CYCLES)) ? cnt_q + CW'(1) : cnt_q;
        lit = ~s1_q[15:8];
        one_hot = (lit != 8'h00) && ((lit & (lit - 8'd1)) == 8'h00);
        dec = (cap && one_hot) ? lit : 8'h00;
        frame = (dec != 8'h00) && ((seen_q | dec) == 8'hFF);
        valid_d = clear ? 8'h00 : valid_q | dec;
        seen_d = (clear || frame) ? 8'h00 : seen_q | dec;
        err_d = !clear && (err_q || (cap && (lit != 8'h00) && !one_hot));
        tick_d = !clear && frame;
    end

    // Sampling pipeline, stability counter and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 16'hFFFF;
            s2_q <= 16'hFFFF;
            cnt_q <= '0;
            valid_q <= 8'h00;
            seen_q <= 8'h00;
            err_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            s1_q <= {an_in, sseg_in};
            s2_q <= s1_q;
            cnt_q <= cnt_d;
            valid_q <= valid_d;
            seen_q <= seen_d;
            err_q <= err_d;
            tick_q <= tick_d;
        end
    end

    // Per-digit byte capture; written even when clear drops the status update
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++)
            if (reset) out_q[k] <= 8'hFF;
            else if (dec[k]) out_q[k] <= s1_q[7:0];
    end

    assign {out7, out6, out5, out4, out3, out2, out1, out0} =
        {out_q[7], out_q[6], out_q[5], out_q[4], out_q[3], out_q[2], out_q[1], out_q[0]};
    assign valid = valid_q;
    assign frame_tick = tick_q;
    assign err_multi = err_q;
endmodule
